// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM states and opcode classes shared by control_unit.
// State T6 exists only when MULDIV_EN is defined.
package cpu_pkg;

  localparam int OPCODE_W = 5;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MUL  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RESET,
    T0,
    T1,
    T2,
    T3,
    T4,
    T5,
`ifdef MULDIV_EN
    T6,
`endif
    HALT
  } state_t;

  typedef enum logic [2:0] {
    BIN,
    UNARY,
    MULDIV,
    NOP,
    HALT_ILL
  } op_class_t;

endpackage

// File: rtl/control_decode.sv
// control_decode: maps the IR opcode field to an execute-sequence class.
// mul/div count as illegal unless MULDIV_EN is defined.
module control_decode
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] opcode,
  output op_class_t           op_class
);

  always_comb begin
    op_class = HALT_ILL;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND,
      OP_OR, OP_ROR, OP_ROL,
      OP_SHR, OP_SHRA, OP_SHL: op_class = BIN;
      OP_NEG, OP_NOT:          op_class = UNARY;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV:          op_class = MULDIV;
`else
      OP_MUL, OP_DIV:          op_class = HALT_ILL;
`endif
      OP_NOP:                  op_class = NOP;
      OP_HALT:                 op_class = HALT_ILL;
      default:                 op_class = HALT_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: hardwired Moore fetch/execute sequencer for the bus datapath.
// Define MULDIV_EN to build the mul/div sequence (T6, HI/LO, ZHigh strobes).
module control_unit
  import cpu_pkg::*;
#(
  parameter int OPW = 5
) (
  input  logic           Clock,
  input  logic           Clear,
  input  logic [31:0]    IR,
  input  logic           Mem_ready,
  input  logic           Stop,
  output logic           PCout,
  output logic           MDRout,
  output logic           Zlowout,
  output logic           ZHighout,
  output logic           MARin,
  output logic           PCin,
  output logic           MDRin,
  output logic           IRin,
  output logic           Yin,
  output logic           ZLowIn,
  output logic           ZHighIn,
  output logic           HIin,
  output logic           LOin,
  output logic           IncPC,
  output logic           Read,
  output logic           Gra,
  output logic           Grb,
  output logic           Grc,
  output logic           Rin,
  output logic           Rout,
  output logic [OPW-1:0] alu_op,
  output logic           Run
);

  state_t    state;
  state_t    next_state;
  state_t    end_state;
  op_class_t op_class;
  logic      rst_done;
  logic      stop_pending;
  logic      alu_en;
  logic      unused_ir;

  assign unused_ir = ^IR[26:0];

  control_decode u_decode (
    .opcode   (IR[31:27]),
    .op_class (op_class)
  );

  // rst_done holds RESET for one full cycle after Clear releases
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state        <= RESET;
      rst_done     <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      state    <= next_state;
      rst_done <= 1'b1;
      if (Stop) stop_pending <= 1'b1;
    end
  end

  assign end_state = (stop_pending || Stop) ? HALT : T0;
  assign alu_op    = alu_en ? IR[31 -: OPW] : '0;
  assign Run       = (state != RESET) && (state != HALT);

  always_comb begin
    next_state = state;
    alu_en     = 1'b0;
    PCout      = 1'b0;
    MDRout     = 1'b0;
    Zlowout    = 1'b0;
    ZHighout   = 1'b0;
    MARin      = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    unique case (state)
      RESET: next_state = rst_done ? T0 : RESET;
      T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
        next_state = T1;
      end
      T1: begin
        Read = 1'b1; MDRin = 1'b1;
        if (Mem_ready) next_state = T2;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = T3;
      end
      T3: begin
        unique case (op_class)
          BIN: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
            next_state = T4;
          end
          UNARY: begin
            Grb = 1'b1; Rout = 1'b1;
            alu_en = 1'b1; ZLowIn = 1'b1;
            next_state = T4;
          end
`ifdef MULDIV_EN
          MULDIV: begin
            Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
            next_state = T4;
          end
`endif
          NOP:     next_state = end_state;
          default: next_state = HALT;
        endcase
      end
      T4: begin
        unique case (op_class)
          BIN: begin
            Grc = 1'b1; Rout = 1'b1;
            alu_en = 1'b1; ZLowIn = 1'b1;
            next_state = T5;
          end
          UNARY: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            next_state = end_state;
          end
`ifdef MULDIV_EN
          MULDIV: begin
            Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1;
            ZHighIn = 1'b1; ZLowIn = 1'b1;
            next_state = T5;
          end
`endif
          default: next_state = HALT;
        endcase
      end
      T5: begin
        unique case (op_class)
          BIN: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
            next_state = end_state;
          end
`ifdef MULDIV_EN
          MULDIV: begin
            Zlowout = 1'b1; LOin = 1'b1;
            next_state = T6;
          end
`endif
          default: next_state = HALT;
        endcase
      end
`ifdef MULDIV_EN
      T6: begin
        ZHighout = 1'b1; HIin = 1'b1;
        next_state = end_state;
      end
`endif
      HALT:    next_state = HALT;
      default: next_state = HALT;
    endcase
  end

endmodule
